// File: rtl/key_pulse_gen.sv
// key_pulse_gen: debounced push-button to single-step pulse generator.
// A free-running prescaler produces the enable strobe. A four-state debounce FSM,
// clocked by that strobe, accepts presses and releases. Each accepted press sets a
// pending flag, which is issued as a one-cycle 'a' pulse on the next strobe.
// Optional feature macro: KEY_AUTOREPEAT_EN. When it is defined, holding the key
// re-arms the pulse after REPEAT_DELAY strobes and then every REPEAT_RATE strobes.
module key_pulse_gen #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned DB_TICKS     = 20,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_n,
  output logic       enable,
  output logic       a,
  output logic       key_level,
  output logic [7:0] press_cnt
);

  // Reject out-of-range configurations at elaboration.
  if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_bad_tick_div
    $error("TICK_DIV out of range 2..65535");
  end
  if (DB_TICKS < 1 || DB_TICKS > 255) begin : g_bad_db_ticks
    $error("DB_TICKS out of range 1..255");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 65535) begin : g_bad_repeat_delay
    $error("REPEAT_DELAY out of range 1..65535");
  end
  if (REPEAT_RATE < 1 || REPEAT_RATE > 65535) begin : g_bad_repeat_rate
    $error("REPEAT_RATE out of range 1..65535");
  end

  localparam logic [15:0] PreMax   = 16'(TICK_DIV - 1);
  localparam logic [7:0]  DbTarget = 8'(DB_TICKS);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StPressWait = 2'd1,
    StHeld      = 2'd2,
    StRelWait   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer. The flops reset to the released level (key_n high).
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic key_s;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = ~sync2_q;

  // ---------------------------------------------------------------------------
  // Prescaler. enable_q is registered from the next count, so it is high
  // exactly while pre_q == TICK_DIV-1.
  // ---------------------------------------------------------------------------
  logic [15:0] pre_q, pre_d;
  logic        enable_q, enable_d;

  // Next prescaler count and strobe.
  always_comb begin
    pre_d    = (pre_q == PreMax) ? 16'd0 : pre_q + 16'd1;
    enable_d = (pre_d == PreMax);
  end

  // Prescaler and strobe registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q    <= 16'd0;
      enable_q <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      enable_q <= enable_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM and pulse issue.
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [7:0]  db_cnt_q, db_cnt_d;
  logic [7:0]  db_inc;
  logic        pending_q, pending_d;
  logic [7:0]  press_cnt_q, press_cnt_d;
  logic        set_req;
  logic        a_fire;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [15:0] RepDelay = 16'(REPEAT_DELAY);
  localparam logic [15:0] RepRate  = 16'(REPEAT_RATE);

  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic [15:0] rep_inc;
  logic [15:0] rep_target;
  // High until the first auto-repeat of a hold has fired.
  logic        rep_first_q, rep_first_d;

  assign rep_inc    = rep_cnt_q + 16'd1;
  assign rep_target = rep_first_q ? RepDelay : RepRate;
`endif

  assign db_inc = db_cnt_q + 8'd1;
  assign a_fire = pending_q & enable_q;

  // Next-state logic for the debounce FSM and its counters.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    set_req  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
`endif
    case (state_q)
      StIdle: begin
        if (key_s) begin
          state_d  = StPressWait;
          db_cnt_d = 8'd0;
        end
      end
      StPressWait: begin
        if (!key_s) begin
          state_d = StIdle;
        end else if (enable_q) begin
          db_cnt_d = db_inc;
          if (db_inc == DbTarget) begin
            state_d = StHeld;
            set_req = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_d   = 16'd0;
            rep_first_d = 1'b1;
`endif
          end
        end
      end
      StHeld: begin
        if (!key_s) begin
          state_d  = StRelWait;
          db_cnt_d = 8'd0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (enable_q) begin
          if (rep_inc == rep_target) begin
            set_req     = 1'b1;
            rep_cnt_d   = 16'd0;
            rep_first_d = 1'b0;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
`endif
      end
      StRelWait: begin
        // A bounce back to pressed resumes the hold without a new pulse.
        if (key_s) begin
          state_d = StHeld;
        end else if (enable_q) begin
          db_cnt_d = db_inc;
          if (db_inc == DbTarget) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending flag and pulse counter; a set wins over the clear from a firing pulse.
  always_comb begin
    pending_d   = set_req | (pending_q & ~a_fire);
    press_cnt_d = press_cnt_q + {7'd0, a_fire};
  end

  // FSM state, counters, pending flag and pulse count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      db_cnt_q    <= 8'd0;
      pending_q   <= 1'b0;
      press_cnt_q <= 8'd0;
`ifdef KEY_AUTOREPEAT_EN
      rep_cnt_q   <= 16'd0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      pending_q   <= pending_d;
      press_cnt_q <= press_cnt_d;
`ifdef KEY_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign enable    = enable_q;
  assign a         = a_fire;
  assign key_level = (state_q == StHeld) || (state_q == StRelWait);
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Testbench for key_pulse_gen with TICK_DIV=4, DB_TICKS=3, REPEAT_DELAY=5,
// REPEAT_RATE=2. Expected 'a' pulses (cycle and press_cnt value) are queued when a
// press is driven and popped by a monitor when the DUT pulses. Cycle numbers
// count rising edges since reset release.
module tb_key_pulse_gen;

  localparam int TickDiv  = 4;
  localparam int DbTicks  = 3;
  localparam int RepDelay = 5;
  localparam int RepRate  = 2;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_n   = 1'b1;
  logic       enable;
  logic       a;
  logic       key_level;
  logic [7:0] press_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] exp_cnt = 8'd0;
  int         s3;

  key_pulse_gen #(
    .TICK_DIV    (TickDiv),
    .DB_TICKS    (DbTicks),
    .REPEAT_DELAY(RepDelay),
    .REPEAT_RATE (RepRate)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .key_n    (key_n),
    .enable   (enable),
    .a        (a),
    .key_level(key_level),
    .press_cnt(press_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Edge at which the third counted strobe moves the FSM into HELD, for a key
  // first captured by the synchronizer at edge p: key_s is seen from edge p+2,
  // so strobe edges (multiples of TickDiv) are counted from edge p+3.
  function automatic int s3_of(input int p);
    return ((p + 3 + TickDiv - 1) / TickDiv) * TickDiv + TickDiv * (DbTicks - 1);
  endfunction

  // Monitor: strobe phase every cycle, and every 'a' pulse against the scoreboard.
  always @(negedge clock) begin
    if (reset_n) begin
      check("enable_phase", {31'd0, enable}, {31'd0, (cyc % TickDiv) == (TickDiv - 1)});
      if (a === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("a_unexpected", {31'd0, a}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("a_cycle", cyc, mon_e.cyc);
          check("a_press_cnt", {24'd0, press_cnt}, {24'd0, mon_e.cnt});
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    do @(negedge clock); while (cyc < n);
  endtask

  task automatic press_begin(input bit push, output int s3_o);
    int p;
    @(negedge clock);
    p = cyc + 1;
    #1 key_n = 1'b0;
    s3_o = s3_of(p);
    if (push) begin
      sb_q.push_back('{s3_o + TickDiv - 1, exp_cnt});
      exp_cnt++;
    end
  endtask

  task automatic release_key();
    @(negedge clock);
    #1 key_n = 1'b1;
    repeat (24) @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    key_n   = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_a", {31'd0, a}, 32'd0);
    check("rst_key_level", {31'd0, key_level}, 32'd0);
    check("rst_press_cnt", {24'd0, press_cnt}, 32'd0);
    #1 reset_n = 1'b1;

    repeat (20) @(negedge clock);
    check("idle_press_cnt", {24'd0, press_cnt}, 32'd0);
    check("idle_key_level", {31'd0, key_level}, 32'd0);

`ifndef KEY_AUTOREPEAT_EN
    // Clean press held for about 20 strobes.
    press_begin(1'b1, s3);
    wait_cyc(s3 - 1);
    check("level_before_accept", {31'd0, key_level}, 32'd0);
    wait_cyc(s3);
    check("level_after_accept", {31'd0, key_level}, 32'd1);
    repeat (80) @(negedge clock);
    check("clean_press_cnt", {24'd0, press_cnt}, 32'd1);
    release_key();
    check("clean_release_level", {31'd0, key_level}, 32'd0);

    // Bounce: two strobes pressed, two released, five times.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1 key_n = 1'b0;
      repeat (2 * TickDiv) begin
        @(negedge clock);
        check("bounce_level_lo", {31'd0, key_level}, 32'd0);
      end
      #1 key_n = 1'b1;
      repeat (2 * TickDiv) begin
        @(negedge clock);
        check("bounce_level_hi", {31'd0, key_level}, 32'd0);
      end
    end
    check("bounce_press_cnt", {24'd0, press_cnt}, 32'd1);

    // One-strobe release glitch while held.
    press_begin(1'b1, s3);
    wait_cyc(s3 + 2 * TickDiv);
    #1 key_n = 1'b1;
    repeat (TickDiv) begin
      @(negedge clock);
      check("glitch_level", {31'd0, key_level}, 32'd1);
    end
    #1 key_n = 1'b0;
    repeat (24) begin
      @(negedge clock);
      check("glitch_level_after", {31'd0, key_level}, 32'd1);
    end
    release_key();
    check("glitch_press_cnt", {24'd0, press_cnt}, 32'd2);

    // Reset after acceptance but before the pulse: pulse dropped, key re-debounced.
    press_begin(1'b0, s3);
    wait_cyc(s3 + 1);
    check("midpress_level", {31'd0, key_level}, 32'd1);
    #1 reset_n = 1'b0;
    @(negedge clock);
    check("midpress_rst_a", {31'd0, a}, 32'd0);
    check("midpress_rst_cnt", {24'd0, press_cnt}, 32'd0);
    check("midpress_rst_level", {31'd0, key_level}, 32'd0);
    sb_q.delete();
    exp_cnt = 8'd0;
    #1 reset_n = 1'b1;
    // Key still held: synchronizer captures it at edge 1.
    s3 = s3_of(1);
    sb_q.push_back('{s3 + TickDiv - 1, exp_cnt});
    exp_cnt++;
    wait_cyc(s3 + 2 * TickDiv);
    release_key();
    check("midpress_press_cnt", {24'd0, press_cnt}, 32'd1);

    // 255 more presses make 256 pulses since reset: the count wraps to 0.
    for (int i = 0; i < 255; i++) begin
      if (i == 254) check("cnt_before_wrap", {24'd0, press_cnt}, 32'd255);
      press_begin(1'b1, s3);
      wait_cyc(s3 + TickDiv);
      release_key();
    end
    check("press_cnt_wrap", {24'd0, press_cnt}, 32'd0);
`else
    // Held key: first pulse, then repeats after RepDelay and every RepRate strobes.
    press_begin(1'b1, s3);
    for (int r = 0; r < 3; r++) begin
      sb_q.push_back('{s3 + TickDiv * (RepDelay + r * RepRate) + TickDiv - 1, exp_cnt});
      exp_cnt++;
    end
    // Pending is set again at edge s3 + TickDiv*(RepDelay+3*RepRate); reset just after.
    wait_cyc(s3 + TickDiv * (RepDelay + 3 * RepRate) + 1);
    check("rep_press_cnt", {24'd0, press_cnt}, 32'd4);
    check("rep_level", {31'd0, key_level}, 32'd1);
    #1 reset_n = 1'b0;
    key_n = 1'b1;
    @(negedge clock);
    check("rep_rst_a", {31'd0, a}, 32'd0);
    check("rep_rst_cnt", {24'd0, press_cnt}, 32'd0);
    check("rep_rst_level", {31'd0, key_level}, 32'd0);
    sb_q.delete();
    exp_cnt = 8'd0;
    repeat (3) @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("rep_after_rst_cnt", {24'd0, press_cnt}, 32'd0);
`endif

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
